// File: rtl/midi_out.sv
// midi_out: MIDI transmitter. Serialises queued bytes onto a 31,250 baud
// UART line (start bit low, 8 data bits LSB first, stop bit high). A small
// FIFO lets the note/controller logic queue a short multi-byte message in
// one burst while frames go out back to back.
//
// Ports
//   clock          system clock, all logic on rising edge
//   reset          asynchronous active-high reset, clears all state
//   byteInput      byte to queue for transmission
//   byteInputValid byteInput is valid this cycle
//   byteInputReady FIFO can accept a byte (registered count only)
//   uartStream     registered serial MIDI line, idles high
//   busy           frame in progress or FIFO non-empty
//   fifoLevel      current FIFO occupancy
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) on the line
// DATA  | data bit bitIdx on the line, LSB first
// STOP  | stop bit (high); may chain straight into the next START
module midi_out #(
   parameter int CLKS_PER_BIT = 1600,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [7:0]                    byteInput,
   input  logic                          byteInputValid,
   output logic                          byteInputReady,
   output logic                          uartStream,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int LVL_W    = PTR_W + 1;
   localparam int CNT_BITS = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_BITS-1:0] CLK_LAST  = CNT_BITS'(CLKS_PER_BIT - 1);
   localparam logic [LVL_W-1:0]    DEPTH_LVL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]     count_q;
   logic [7:0]           shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic [CNT_BITS-1:0]  clk_cnt_q, clk_cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic                 push, pop, bit_done, fifo_nonempty;

   assign byteInputReady = (count_q != DEPTH_LVL);
   assign push           = byteInputValid && byteInputReady;
   assign fifo_nonempty  = (count_q != '0);
   assign bit_done       = (clk_cnt_q == CLK_LAST);

   assign uartStream = tx_q;
   assign fifoLevel  = count_q;
   assign busy       = (state_q != IDLE) || fifo_nonempty;

   // Next state. The shift register is loaded straight from the FIFO head on
   // the same edge the start bit is driven, so the frame is independent of
   // any later changes on byteInput.
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (fifo_nonempty) begin
               pop       = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               tx_d      = 1'b0;
               clk_cnt_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (bit_done) begin
               tx_d      = shift_q[0];
               bit_idx_d = 3'd0;
               clk_cnt_d = '0;
               state_d   = DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_BITS'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_BITS'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               // Chain directly into the next start bit: no idle gap.
               if (fifo_nonempty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_BITS'(1);
            end
         end
         default: begin
            tx_d      = 1'b1;
            clk_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tx_q      <= 1'b1;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // FIFO pointers and count. Pointer width is log2(depth), so wrap is free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + LVL_W'(1);
            2'b01:   count_q <= count_q - LVL_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= byteInput;
   end

endmodule

// File: tb/tb_midi_out.sv
module tb_midi_out;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int FRAME = 10 * CPB;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [7:0]       byteInput = 8'h00;
   logic             byteInputValid = 1'b0;
   logic             byteInputReady;
   logic             uartStream;
   logic             busy;
   logic [LVL_W-1:0] fifoLevel;

   int vecs = 0;
   int miscomp = 0;

   midi_out #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
      .byteInput      (byteInput),
      .byteInputValid (byteInputValid),
      .byteInputReady (byteInputReady),
      .uartStream     (uartStream),
      .busy           (busy),
      .fifoLevel      (fifoLevel)
   );

   always #5 clock = ~clock;

   // ---------------- frame-level behavioural model ----------------
   logic [7:0] mq[$];
   bit         m_active = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_cur = 8'h00;

   function automatic logic exp_line();
      int idx;
      if (!m_active) return 1'b1;
      idx = m_pos / CPB;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return m_cur[idx-1];
      return 1'b1;
   endfunction

   initial forever begin
      bit acc;
      @(posedge clock or posedge reset);
      if (reset) begin
         mq.delete();
         m_active = 1'b0;
         m_pos    = 0;
      end else begin
         acc = byteInputValid && (mq.size() != DEPTH);
         if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) begin
               if (mq.size() > 0) begin
                  m_cur = mq.pop_front();
                  m_pos = 0;
               end else begin
                  m_active = 1'b0;
               end
            end
         end else if (mq.size() > 0) begin
            m_cur    = mq.pop_front();
            m_pos    = 0;
            m_active = 1'b1;
         end
         if (acc) mq.push_back(byteInput);
      end
   end

   // Per-cycle compare of all outputs against the model.
   initial forever begin
      logic             el, er, eb;
      logic [LVL_W-1:0] ev;
      @(negedge clock);
      el = exp_line();
      ev = LVL_W'(mq.size());
      er = (mq.size() != DEPTH);
      eb = m_active || (mq.size() != 0);
      vecs++;
      if (uartStream !== el || byteInputReady !== er || busy !== eb || fifoLevel !== ev) begin
         miscomp++;
         $display("FAIL t=%0t outputs line/ready/busy/level got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                  $time, uartStream, byteInputReady, busy, fifoLevel, el, er, eb, ev);
      end
   end

   // ---------------- independent serial receiver ----------------
   logic [7:0] rx_q[$];
   int         rx_ferr = 0;

   initial begin
      bit         rx_on = 1'b0;
      logic       rx_prev = 1'b1;
      int         rx_t = 0;
      int         k;
      logic [7:0] rx_sh = 8'h00;
      forever begin
         @(negedge clock);
         if (reset) begin
            rx_on   = 1'b0;
            rx_prev = 1'b1;
         end else begin
            if (rx_on) begin
               rx_t++;
               if (rx_t % CPB == CPB / 2) begin
                  k = rx_t / CPB;
                  if (k >= 1 && k <= 8) rx_sh[k-1] = uartStream;
                  else if (k == 9) begin
                     rx_q.push_back(rx_sh);
                     if (!uartStream) rx_ferr++;
                     rx_on = 1'b0;
                  end
               end
            end else if (rx_prev && !uartStream) begin
               rx_on = 1'b1;
               rx_t  = 0;
            end
            rx_prev = uartStream;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         miscomp++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      @(negedge clock);
      while (busy && n < limit) begin
         @(negedge clock);
         n++;
      end
      check("reach_idle", int'(busy), 0);
   endtask

   task automatic check_rx(input string name, input logic [7:0] exp);
      if (rx_q.size() == 0) check({name, "_missing"}, 0, 1);
      else check(name, int'(rx_q.pop_front()), int'(exp));
   endtask

   task automatic push_when_ready(input logic [7:0] b);
      int n = 0;
      @(negedge clock);
      while (!byteInputReady && n < 4 * FRAME) begin
         @(negedge clock);
         n++;
      end
      check("push_ready", int'(byteInputReady), 1);
      byteInput      = b;
      byteInputValid = 1'b1;
      tick();
      byteInputValid = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      logic [9:0] pat;
      int         acc_n, c, highs;
      logic [7:0] lb [18];

      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_line", int'(uartStream), 1);
      check("rst_ready", int'(byteInputReady), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_level", int'(fifoLevel), 0);

      // 1: single byte 0x90, one-edge latency, exact frame length
      wait_idle(10);
      byteInput = 8'h90; byteInputValid = 1'b1;
      tick();
      byteInputValid = 1'b0;
      @(negedge clock);
      check("t1_line_E0", int'(uartStream), 1);
      check("t1_level_E0", int'(fifoLevel), 1);
      @(negedge clock);
      check("t1_line_E1", int'(uartStream), 0);
      pat = 10'b1100100000;
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clock);
         if (j % CPB == CPB / 2) check($sformatf("t1_bit%0d", j / CPB), int'(uartStream), int'(pat[j / CPB]));
         if (j == FRAME - 1) check("t1_busy_last", int'(busy), 1);
         if (j == FRAME) check("t1_busy_end", int'(busy), 0);
      end
      check_rx("t1_rx", 8'h90);

      // 2: back-to-back three bytes
      wait_idle(10);
      byteInputValid = 1'b1;
      byteInput = 8'h90; tick();
      byteInput = 8'h3C; tick();
      byteInput = 8'h7F; tick();
      byteInputValid = 1'b0;
      c = 0;
      @(negedge clock);
      while (busy && c < 5 * FRAME) begin
         c++;
         @(negedge clock);
      end
      check("t2_busy_cycles", c, 3 * FRAME - 1);
      check_rx("t2_rx0", 8'h90);
      check_rx("t2_rx1", 8'h3C);
      check_rx("t2_rx2", 8'h7F);

      // 3: fill the FIFO, ready timing
      wait_idle(10);
      acc_n = 0;
      for (int i = 0; i < 6; i++) begin
         byteInput = 8'hA0 + 8'(i);
         byteInputValid = 1'b1;
         if (byteInputReady) acc_n++;
         tick();
      end
      byteInputValid = 1'b0;
      check("t3_accepted", acc_n, 5);
      @(negedge clock);
      check("t3_level_full", int'(fifoLevel), 4);
      check("t3_ready_full", int'(byteInputReady), 0);
      for (int j = 6; j <= FRAME + 1; j++) begin
         @(negedge clock);
         if (j == FRAME) check("t3_ready_before", int'(byteInputReady), 0);
         if (j == FRAME + 1) begin
            check("t3_ready_after", int'(byteInputReady), 1);
            check("t3_level_after", int'(fifoLevel), 3);
         end
      end
      wait_idle(6 * FRAME);
      for (int i = 0; i < 5; i++) check_rx($sformatf("t3_rx%0d", i), 8'hA0 + 8'(i));

      // 4: reset during bit 3 of 0x55 with two bytes queued
      wait_idle(10);
      byteInputValid = 1'b1;
      byteInput = 8'h55; tick();
      byteInput = 8'h11; tick();
      byteInput = 8'h22; tick();
      byteInputValid = 1'b0;
      repeat (70) tick();
      check("t4_level_pre", int'(fifoLevel), 2);
      #1 reset = 1'b1;
      #1;
      check("t4_line_async", int'(uartStream), 1);
      check("t4_level_async", int'(fifoLevel), 0);
      check("t4_busy_async", int'(busy), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      highs = 0;
      for (int j = 0; j < 200; j++) begin
         @(negedge clock);
         if (uartStream) highs++;
      end
      check("t4_line_high", highs, 200);
      check("t4_rx_empty", rx_q.size(), 0);

      // 5: loopback sequence
      for (int i = 0; i < 16; i++) lb[i] = 8'h80 + 8'(i);
      lb[16] = 8'h00;
      lb[17] = 8'hFF;
      for (int i = 0; i < 18; i++) push_when_ready(lb[i]);
      wait_idle(6 * FRAME);
      for (int i = 0; i < 18; i++) check_rx($sformatf("t5_rx%0d", i), lb[i]);
      check("t5_framing", rx_ferr, 0);

      // 6: push on the STOP->START pop edge
      wait_idle(10);
      byteInputValid = 1'b1;
      byteInput = 8'h12; tick();
      byteInput = 8'h34; tick();
      byteInputValid = 1'b0;
      repeat (FRAME - 1) tick();
      @(negedge clock);
      check("t6_level_pre", int'(fifoLevel), 1);
      check("t6_line_stop", int'(uartStream), 1);
      byteInput = 8'h56; byteInputValid = 1'b1;
      tick();
      byteInputValid = 1'b0;
      @(negedge clock);
      check("t6_level_post", int'(fifoLevel), 1);
      check("t6_line_start", int'(uartStream), 0);
      wait_idle(4 * FRAME);
      check_rx("t6_rx0", 8'h12);
      check_rx("t6_rx1", 8'h34);
      check_rx("t6_rx2", 8'h56);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
      $finish;
   end

endmodule
